// File: rtl/jb_clk_en_car_mc_if.sv
// Carrier-control bundle between the configuration registers and the clock-enable controller.
interface jb_clk_en_car_mc_if #(
    parameter int unsigned NUM_CAR = 4
);
    logic [NUM_CAR-1:0]   car_en;
    logic [2*NUM_CAR-1:0] car_bw;
    logic [NUM_CAR-1:0]   clk_en;
    logic [NUM_CAR-1:0]   clk_fft_en;
    logic [NUM_CAR-1:0]   car_resetn;
    logic [NUM_CAR-1:0]   dfe_flush;
    logic [NUM_CAR-1:0]   car_busy;
    logic                 all_idle;

    modport master (
        output car_en, car_bw,
        input  clk_en, clk_fft_en, car_resetn, dfe_flush, car_busy, all_idle
    );

    modport slave (
        input  car_en, car_bw,
        output clk_en, clk_fft_en, car_resetn, dfe_flush, car_busy, all_idle
    );
endinterface

// File: rtl/jb_clk_en_car_mc.sv
// Multi-carrier clock-enable controller with per-carrier enable/flush/reset sequencer.
// Optional on-the-fly bandwidth re-sequencing: define JB_CLK_EN_CAR_BW_CHANGE_EN.
module jb_clk_en_car_mc #(
    parameter int unsigned NUM_CAR      = 4,
    parameter int unsigned FLUSH_CYCLES = 2048,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    jb_clk_en_car_mc_if.slave bus
);
    localparam int unsigned DIV_W = 4;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_RUN, S_FLUSH, S_RST_ON, S_CLK_OFF, S_RST_OFF
    } state_t;

    state_t             state_q [NUM_CAR];
    state_t             state_d [NUM_CAR];
    logic [CNT_W-1:0]   cnt_q   [NUM_CAR];
    logic [CNT_W-1:0]   cnt_d   [NUM_CAR];
    logic [DIV_W-1:0]   div_q   [NUM_CAR];
    logic [DIV_W-1:0]   div_d   [NUM_CAR];
    logic [1:0]         bw_q    [NUM_CAR];
    logic [1:0]         bw_d    [NUM_CAR];

    logic [NUM_CAR-1:0] clk_en_q, clk_en_d;
    logic [NUM_CAR-1:0] fft_en_q, fft_en_d;
    logic [NUM_CAR-1:0] resetn_q, resetn_d;
    logic [NUM_CAR-1:0] flush_q, flush_d;
    logic [NUM_CAR-1:0] busy_q, busy_d;
    logic               all_idle_q, all_idle_d;

    // Divider masks: enable fires when the masked div count is zero.
    function automatic logic [DIV_W-1:0] clk_mask(input logic [1:0] bw);
        case (bw)
            2'b01:   return 4'd1;
            2'b10:   return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [DIV_W-1:0] fft_mask(input logic [1:0] bw);
        case (bw)
            2'b01:   return 4'd7;
            2'b10:   return 4'd15;
            default: return 4'd3;
        endcase
    endfunction

    function automatic logic running(input state_t s);
        return (s == S_RUN) || (s == S_FLUSH) || (s == S_RST_ON);
    endfunction

    function automatic logic waiting(input state_t s);
        return (s == S_FLUSH) || (s == S_RST_ON) || (s == S_CLK_OFF) || (s == S_RST_OFF);
    endfunction

    always_comb begin
        clk_en_d   = '0;
        fft_en_d   = '0;
        resetn_d   = '0;
        flush_d    = '0;
        busy_d     = '0;
        all_idle_d = &(~busy_q);
        for (int n = 0; n < NUM_CAR; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            div_d[n]   = div_q[n];
            bw_d[n]    = bw_q[n];

            case (state_q[n])
                S_IDLE: begin
                    if (bus.car_en[n]) begin
                        bw_d[n]    = bus.car_bw[2*n +: 2];
                        state_d[n] = S_START;
                    end
                end
                S_START: begin
                    div_d[n]   = '0;
                    state_d[n] = S_RUN;
                end
                S_RUN: begin
                    if (!bus.car_en[n]) begin
                        state_d[n] = S_FLUSH;
                    end
`ifdef JB_CLK_EN_CAR_BW_CHANGE_EN
                    else if (bus.car_bw[2*n +: 2] != bw_q[n]) begin
                        state_d[n] = S_FLUSH;
                    end
`endif
                end
                S_FLUSH:   if (cnt_q[n] == FLUSH_LAST) state_d[n] = S_RST_ON;
                S_RST_ON:  if (cnt_q[n] == RST_LAST)   state_d[n] = S_CLK_OFF;
                S_CLK_OFF: if (cnt_q[n] == RST_LAST)   state_d[n] = S_RST_OFF;
                S_RST_OFF: if (cnt_q[n] == RST_LAST)   state_d[n] = S_IDLE;
                default:   state_d[n] = S_IDLE;
            endcase

            if (state_d[n] != state_q[n]) begin
                cnt_d[n] = '0;
            end else if (waiting(state_q[n])) begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end

            // Enables run until the edge that enters CLK_OFF.
            if (running(state_q[n])) begin
                div_d[n] = div_q[n] + DIV_W'(1);
                if (state_d[n] != S_CLK_OFF) begin
                    clk_en_d[n] = (div_q[n] & clk_mask(bw_q[n])) == '0;
                    fft_en_d[n] = (div_q[n] & fft_mask(bw_q[n])) == '0;
                end
            end

            resetn_d[n] = !((state_d[n] == S_RST_ON) || (state_d[n] == S_CLK_OFF));
            flush_d[n]  = waiting(state_q[n]);
            busy_d[n]   = state_q[n] != S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NUM_CAR; n++) begin
                state_q[n] <= S_IDLE;
                cnt_q[n]   <= '0;
                div_q[n]   <= '0;
                bw_q[n]    <= '0;
            end
            clk_en_q   <= '0;
            fft_en_q   <= '0;
            resetn_q   <= '0;
            flush_q    <= '0;
            busy_q     <= '0;
            all_idle_q <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_CAR; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
                div_q[n]   <= div_d[n];
                bw_q[n]    <= bw_d[n];
            end
            clk_en_q   <= clk_en_d;
            fft_en_q   <= fft_en_d;
            resetn_q   <= resetn_d;
            flush_q    <= flush_d;
            busy_q     <= busy_d;
            all_idle_q <= all_idle_d;
        end
    end

    assign bus.clk_en     = clk_en_q;
    assign bus.clk_fft_en = fft_en_q;
    assign bus.car_resetn = resetn_q;
    assign bus.dfe_flush  = flush_q;
    assign bus.car_busy   = busy_q;
    assign bus.all_idle   = all_idle_q;
endmodule

// File: doc/jb_clk_en_car_mc.md
# jb_clk_en_car_mc

Multi-carrier, parametrised successor to the single-carrier clock-enable controller. It generates per-carrier data-rate and FFT clock enables from one clock, with an independent enable/flush/reset sequencer per carrier. It also adds optional on-the-fly bandwidth re-sequencing. It sits between the carrier configuration registers and the per-carrier DFE/FFT pipelines.

## Interface
- NUM_CAR, 4, number of independent carriers (1..16)
- FLUSH_CYCLES, 2048, DFE pipeline flush duration in clk cycles (≥2)
- RST_CYCLES, 16, duration of each reset/clock-off wait phase in clk cycles (≥2)
- CNT_W, 16, width of per-carrier sequencer counter; must hold max(FLUSH_CYCLES, RST_CYCLES)-1

- clk  input  1  single clock; all logic and outputs synchronous to it
- reset  input  1  synchronous, active-high
- car_en  input  NUM_CAR  per-carrier enable level, synchronous to clk
- car_bw  input  2*NUM_CAR  per-carrier bandwidth, carrier n at [2n+1:2n]: 00=20 MHz, 01=10 MHz, 10=5 MHz, 11=15 MHz
- clk_en  output  NUM_CAR  per-carrier data-rate enable, registered
- clk_fft_en  output  NUM_CAR  per-carrier FFT/IFFT enable, registered
- car_resetn  output  NUM_CAR  per-carrier downstream reset, active-low, registered
- dfe_flush  output  NUM_CAR  high while carrier is in any shutdown state
- car_busy  output  NUM_CAR  high whenever carrier state ≠ IDLE
- all_idle  output  1  AND of ~car_busy, registered

## Operation
- Per-carrier FSM: IDLE → START → RUN → FLUSH → RST_ON → CLK_OFF → RST_OFF → IDLE.
- IDLE: car_en=1 latches car_bw into bw_lat and moves to START. car_en is level-sensitive. It is ignored in every state other than IDLE and RUN.
- START: one cycle; clears the 4-bit div_cnt; moves to RUN.
- RUN:
  - div_cnt increments and wraps every cycle.
  - clk_en_next = (div_cnt mod DIV)==0, with DIV = 1/2/4/1 for bw 00/01/10/11.
  - clk_fft_en_next = (div_cnt mod FDIV)==0, with FDIV = 4/8/16/4.
  - car_en=0 moves to FLUSH.
- FLUSH: enables keep running; lasts exactly FLUSH_CYCLES cycles; then RST_ON.
- RST_ON: car_resetn=0; enables keep running; RST_CYCLES cycles; then CLK_OFF.
- CLK_OFF: car_resetn=0; clk_en and clk_fft_en forced 0; RST_CYCLES cycles; then RST_OFF.
- RST_OFF: car_resetn=1; enables 0; RST_CYCLES cycles; then IDLE.
- car_resetn=1 in IDLE, START and RUN.
- dfe_flush=1 in FLUSH, RST_ON, CLK_OFF and RST_OFF.
- The sequencer counter clears on every state change and counts only in wait states.
- Carriers are fully independent. Simultaneous events on different carriers never interact.
- Re-enable during shutdown: car_en=1 while in FLUSH..RST_OFF has no effect. If car_en is still 1 on return to IDLE, START follows on the next cycle.

## Timing
- Reset values:
  - all states IDLE
  - clk_en=0, clk_fft_en=0, car_resetn=0, dfe_flush=0, car_busy=0, all_idle=0
  - car_resetn and all_idle go 1 one cycle after reset deasserts
- Reset asserted mid-operation: at the next edge, that carrier's state and outputs return to the reset values. No flush is performed.
- Enable latency: car_en=1 sampled in IDLE at edge k gives START after k, RUN after k+1, and first clk_en=1 and clk_fft_en=1 after edge k+2.
- Disable latency: car_en=0 sampled in RUN at edge j gives FLUSH after j. The carrier is back in IDLE after edge j+FLUSH_CYCLES+3·RST_CYCLES.
- Last enable pulse: clk_en can pulse up to the edge that enters CLK_OFF; it is 0 from that cycle onward.
- car_busy and dfe_flush are registered and follow state with 1-cycle latency.
- all_idle lags car_busy by one cycle.

## Configuration
- JB_CLK_EN_CAR_BW_CHANGE_EN defined:
  - In RUN, car_bw ≠ bw_lat (with car_en=1) starts the full shutdown sequence, FLUSH through RST_OFF.
  - Back in IDLE with car_en=1, the new bw is latched and the carrier restarts automatically.
  - car_en=0 and a bw change in the same cycle are treated as a plain disable.
- Macro undefined: car_bw is sampled only on the IDLE→START transition. Changes during RUN are ignored until the next enable.

## Test plan
- Reset, then car_en[0]=1 with bw=00 at edge 10 → clk_en[0]=1 from edge 12 every cycle; clk_fft_en[0] every 4th cycle starting edge 12; car_resetn=1.
- Carrier 1, bw=10, enabled → clk_en[1] high 1 cycle in 4, clk_fft_en[1] 1 in 16, first pulses coincident. Carrier 2 with bw=01 runs concurrently, unaffected: 1 in 2 and 1 in 8.
- car_en[0] dropped at edge j, FLUSH_CYCLES=2048, RST_CYCLES=16:
  - dfe_flush high edges j+1..j+2096
  - car_resetn low after edges j+2048..j+2079
  - clk_en 0 from j+2064
  - IDLE at j+2096
- car_en[0] re-asserted at j+100 (mid-flush) and held → ignored until IDLE; START at j+2097; clk_en resumes at j+2099.
- reset pulsed while carrier 3 is in RST_ON → next cycle: clk_en[3]=0, car_resetn[3]=0, dfe_flush[3]=0, state IDLE.
- With JB_CLK_EN_CAR_BW_CHANGE_EN, car_bw[0] changed 00→01 during RUN → full shutdown sequence, then automatic restart with clk_en[0] at 1 in 2. Without the macro, clk_en[0] stays 1 every cycle.
